// File: rtl/skinny_subcells_hpc2_1_seq.sv
// Byte-serial sequencer for the masked SKINNY-128 SubCells layer around an external HPC2 order-1 sbox8.
// Optional macro SKINNY_SUBCELLS_IDLE_CLEAR_EN clears the sbox input registers while idle.
module skinny_subcells_hpc2_1_seq #(
    parameter int unsigned SBOX_LAT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] si0,
    input  logic [127:0] si1,
    input  logic [7:0]   r_in,
    output logic         rnd_req,
    output logic [7:0]   sb_si0,
    output logic [7:0]   sb_si1,
    output logic [7:0]   sb_r,
    input  logic [7:0]   sb_bo0,
    input  logic [7:0]   sb_bo1,
    output logic [127:0] so0,
    output logic [127:0] so1,
    output logic         busy,
    output logic         done
);
    localparam int unsigned STATE_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SBOX_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(15);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FEED  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
    logic [BYTE_W-1:0]  sb_si0_q, sb_si0_d, sb_si1_q, sb_si1_d, sb_r_q, sb_r_d;
    logic               rnd_req_q, busy_q, done_q;
    logic [6:0]         byte_base;

    assign byte_base = {idx_q, 3'b000};

    // State, datapath and registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            sb_si0_q  <= '0;
            sb_si1_q  <= '0;
            sb_r_q    <= '0;
            rnd_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            sb_si0_q  <= sb_si0_d;
            sb_si1_q  <= sb_si1_d;
            sb_r_q    <= sb_r_d;
            rnd_req_q <= (state_d == S_FEED);
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
        end
    end

    // Sbox inputs are only reloaded in FEED, so they stay put through WAIT and STORE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sh0_d    = sh0_q;
        sh1_d    = sh1_q;
        sb_si0_d = sb_si0_q;
        sb_si1_d = sb_si1_q;
        sb_r_d   = sb_r_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sh0_d   = si0;
                    sh1_d   = si1;
                    idx_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                sb_si0_d = sh0_q[byte_base +: BYTE_W];
                sb_si1_d = sh1_q[byte_base +: BYTE_W];
                sb_r_d   = r_in;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                sh0_d[byte_base +: BYTE_W] = sb_bo0;
                sh1_d[byte_base +: BYTE_W] = sb_bo1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
`ifdef SKINNY_SUBCELLS_IDLE_CLEAR_EN
                    sb_si0_d = '0;
                    sb_si1_d = '0;
                    sb_r_d   = '0;
`else
                    sb_si0_d = sb_si0_q;
                    sb_si1_d = sb_si1_q;
                    sb_r_d   = sb_r_q;
`endif
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FEED;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rnd_req = rnd_req_q;
    assign sb_si0  = sb_si0_q;
    assign sb_si1  = sb_si1_q;
    assign sb_r    = sb_r_q;
    assign so0     = sh0_q;
    assign so1     = sh1_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_skinny_subcells_hpc2_1_seq.sv
// Self-checking bench: two sequencer instances (SBOX_LAT 8 and 3) each driving a behavioural masked sbox.
module tb_skinny_subcells_hpc2_1_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         start0, start1;
    logic [127:0] si0, si1;
    logic [7:0]   r_in;

    logic         o0_req, o0_busy, o0_done, o1_req, o1_busy, o1_done;
    logic [7:0]   o0_sb0, o0_sb1, o0_sbr, o1_sb0, o1_sb1, o1_sbr;
    logic [7:0]   bo0_0, bo1_0, bo0_1, bo1_1;
    logic [127:0] o0_so0, o0_so1, o1_so0, o1_so1;

    localparam logic [127:0] PT = 128'h00112233445566778899AABBCCDDEEFF;

    skinny_subcells_hpc2_1_seq #(.SBOX_LAT(8)) u0 (
        .clk(clk), .rst(rst), .start(start0), .si0(si0), .si1(si1), .r_in(r_in),
        .rnd_req(o0_req), .sb_si0(o0_sb0), .sb_si1(o0_sb1), .sb_r(o0_sbr),
        .sb_bo0(bo0_0), .sb_bo1(bo1_0), .so0(o0_so0), .so1(o0_so1),
        .busy(o0_busy), .done(o0_done));

    skinny_subcells_hpc2_1_seq #(.SBOX_LAT(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .si0(si0), .si1(si1), .r_in(r_in),
        .rnd_req(o1_req), .sb_si0(o1_sb0), .sb_si1(o1_sb1), .sb_r(o1_sbr),
        .sb_bo0(bo0_1), .sb_bo1(bo1_1), .so0(o1_so0), .so1(o1_so1),
        .busy(o1_busy), .done(o1_done));

    // Unmasked SKINNY-128 8-bit sbox as a sequence of mix/permute rounds
    function automatic logic [7:0] mix(input logic [7:0] x);
        return (~(((x >> 1) | x) >> 2) & 8'h11) ^ x;
    endfunction
    function automatic logic [7:0] perm(input logic [7:0] x);
        return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5)
             | ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
    endfunction
    function automatic logic [7:0] s8(input logic [7:0] x);
        logic [7:0] y;
        y = perm(mix(x));
        y = perm(mix(y));
        y = perm(mix(y));
        y = mix(y);
        return (y & 8'hF9) | ((y >> 1) & 8'h02) | ((y << 1) & 8'h04);
    endfunction
    function automatic logic [127:0] sub_bytes(input logic [127:0] p);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s8(p[8*k +: 8]);
        return r;
    endfunction

    // Sbox model: output is only correct once its inputs have been stable for long enough
    int          stab0 = 0, stab1 = 0;
    logic [23:0] last0 = '0, last1 = '0;
    always @(posedge clk) begin
        if ({o0_sb0, o0_sb1, o0_sbr} != last0) begin
            last0 <= {o0_sb0, o0_sb1, o0_sbr};
            stab0 <= 0;
        end else if (stab0 < 1000) stab0 <= stab0 + 1;
        if ({o1_sb0, o1_sb1, o1_sbr} != last1) begin
            last1 <= {o1_sb0, o1_sb1, o1_sbr};
            stab1 <= 0;
        end else if (stab1 < 1000) stab1 <= stab1 + 1;
    end
    always_comb begin
        bo0_0 = o0_sbr;
        bo1_0 = s8(o0_sb0 ^ o0_sb1) ^ o0_sbr ^ ((stab0 >= 7) ? 8'h00 : 8'hFF);
        bo0_1 = o1_sbr;
        bo1_1 = s8(o1_sb0 ^ o1_sb1) ^ o1_sbr ^ ((stab1 >= 2) ? 8'h00 : 8'hFF);
    end

    int vectors = 0, miscompares = 0;
    int obs_done, obs_req, obs_sbbad, obs_busybad, obs_reqpos;
    logic [7:0]   masks [16];
    logic [127:0] obs_so0, obs_so1;
    logic         s_req, s_busy, s_done;
    logic [7:0]   s_sb0, s_sb1, s_sbr;
    logic [127:0] s_so0, s_so1;

    task automatic sample(input int which);
        if (which == 0) begin
            s_req = o0_req; s_busy = o0_busy; s_done = o0_done;
            s_sb0 = o0_sb0; s_sb1 = o0_sb1; s_sbr = o0_sbr; s_so0 = o0_so0; s_so1 = o0_so1;
        end else begin
            s_req = o1_req; s_busy = o1_busy; s_done = o1_done;
            s_sb0 = o1_sb0; s_sb1 = o1_sb1; s_sbr = o1_sbr; s_so0 = o1_so0; s_so1 = o1_so1;
        end
    endtask

    function automatic logic [127:0] exp_sh0();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = masks[k];
        return r;
    endfunction
    function automatic logic [127:0] exp_sh1(input logic [127:0] p);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = s8(p[8*k +: 8]) ^ masks[k];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one run and records what the DUT did; cycle 1 is the first cycle after the accepting edge
    task automatic run(input int which, input logic [127:0] a0, input logic [127:0] a1,
                       input bit toggle, input bit hold);
        int cyc;
        int lat;
        logic prev_req;
        logic [7:0] prev_r;
        logic [23:0] prev_sb;
        lat = (which == 0) ? 8 : 3;
        si0 = a0; si1 = a1; r_in = 8'($urandom);
        if (which == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
        cyc = 0; obs_done = -1; obs_req = 0; obs_sbbad = 0; obs_busybad = 0; obs_reqpos = 0;
        obs_so0 = '0; obs_so1 = '0;
        sample(which);
        prev_sb = {s_sb0, s_sb1, s_sbr}; prev_req = 1'b0; prev_r = '0;
        while (obs_done < 0 && cyc < 400) begin
            if (toggle) begin si0 = rand128(); si1 = rand128(); end
            r_in = 8'($urandom);
            @(negedge clk); cyc++;
            sample(which);
            if ({s_sb0, s_sb1, s_sbr} != prev_sb && !prev_req) obs_sbbad++;
            if (prev_req && obs_req > 0 &&
                {s_sb0, s_sb1, s_sbr} != {a0[8*(obs_req-1) +: 8], a1[8*(obs_req-1) +: 8], prev_r})
                obs_sbbad++;
            prev_req = s_req; prev_r = r_in; prev_sb = {s_sb0, s_sb1, s_sbr};
            if (s_req) begin
                if (obs_req < 16) masks[obs_req] = r_in;
                if ((cyc - 1) % (lat + 2) != 0) obs_reqpos++;
                obs_req++;
            end
            if (!s_busy) obs_busybad++;
            if (s_done) begin obs_done = cyc; obs_so0 = s_so0; obs_so1 = s_so1; end
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [127:0] a0;
        rst = 1'b1; start0 = 0; start1 = 0; si0 = '0; si1 = '0; r_in = '0;
        repeat (3) @(negedge clk);
        sample(0);
        vectors++;
        if ({s_req, s_busy, s_done, s_sb0, s_sb1, s_sbr} !== '0 || s_so0 !== '0 || s_so1 !== '0) begin
            miscompares++; $display("FAIL reset_state: outputs req=%b busy=%b done=%b sb=%h so0=%h required all 0",
                                    s_req, s_busy, s_done, {s_sb0, s_sb1, s_sbr}, s_so0);
        end
        rst = 1'b0;
        a0 = rand128();
        si0 = a0; si1 = a0 ^ PT; start0 = 1'b1; r_in = 8'($urandom);
        @(posedge clk); #1; start0 = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1 sample(0);
        vectors++;
        if (s_busy !== 1'b0 || s_done !== 1'b0 || s_req !== 1'b0) begin
            miscompares++; $display("FAIL reset_async_flags: busy=%b done=%b req=%b required 0", s_busy, s_done, s_req);
        end
        vectors++;
        if (s_so0 !== '0 || s_so1 !== '0 || {s_sb0, s_sb1, s_sbr} !== '0) begin
            miscompares++; $display("FAIL reset_async_data: so0=%h so1=%h sb=%h required 0", s_so0, s_so1, {s_sb0, s_sb1, s_sbr});
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic check_run(input string name, input logic [127:0] p, input int exp_done);
        vectors++;
        if (obs_done !== exp_done) begin
            miscompares++; $display("FAIL %s_done_cycle: got %0d required %0d", name, obs_done, exp_done);
        end
        vectors++;
        if (obs_req !== 16 || obs_reqpos !== 0) begin
            miscompares++; $display("FAIL %s_rnd_req: count %0d misplaced %0d required 16 and 0", name, obs_req, obs_reqpos);
        end
        vectors++;
        if ((obs_so0 ^ obs_so1) !== sub_bytes(p)) begin
            miscompares++; $display("FAIL %s_unmasked: got %h required %h", name, obs_so0 ^ obs_so1, sub_bytes(p));
        end
        vectors++;
        if (obs_so0 !== exp_sh0() || obs_so1 !== exp_sh1(p)) begin
            miscompares++; $display("FAIL %s_shares: got %h/%h required %h/%h", name, obs_so0, obs_so1, exp_sh0(), exp_sh1(p));
        end
        vectors++;
        if (obs_sbbad !== 0 || obs_busybad !== 0) begin
            miscompares++; $display("FAIL %s_stability: sbox-input glitches %0d busy-low cycles %0d required 0", name, obs_sbbad, obs_busybad);
        end
    endtask

    task automatic test_zero_state();
        logic [23:0] exp_sb;
        run(0, '0, '0, 1'b0, 1'b0);
        check_run("zero", '0, 161);
        vectors++;
        if ((obs_so0 ^ obs_so1) !== {16{8'h65}}) begin
            miscompares++; $display("FAIL zero_const: got %h required all 65", obs_so0 ^ obs_so1);
        end
        @(negedge clk); sample(0);
        vectors++;
        if (s_busy !== 1'b0 || s_done !== 1'b0) begin
            miscompares++; $display("FAIL zero_idle_after: busy=%b done=%b required 0", s_busy, s_done);
        end
`ifdef SKINNY_SUBCELLS_IDLE_CLEAR_EN
        exp_sb = '0;
`else
        exp_sb = {8'h00, 8'h00, masks[15]};
`endif
        vectors++;
        if ({s_sb0, s_sb1, s_sbr} !== exp_sb) begin
            miscompares++; $display("FAIL idle_sbox_inputs: got %h required %h", {s_sb0, s_sb1, s_sbr}, exp_sb);
        end
    endtask

    task automatic test_random_shares();
        logic [127:0] a0;
        logic [23:0] exp_sb;
        a0 = rand128();
        run(0, a0, a0 ^ PT, 1'b0, 1'b0);
        check_run("random", PT, 161);
        @(negedge clk); sample(0);
`ifdef SKINNY_SUBCELLS_IDLE_CLEAR_EN
        exp_sb = '0;
`else
        exp_sb = {a0[127:120], a0[127:120] ^ PT[127:120], masks[15]};
`endif
        vectors++;
        if ({s_sb0, s_sb1, s_sbr} !== exp_sb) begin
            miscompares++; $display("FAIL random_idle_sbox_inputs: got %h required %h", {s_sb0, s_sb1, s_sbr}, exp_sb);
        end
    endtask

    task automatic test_lat3();
        logic [127:0] a0, p;
        a0 = rand128(); p = rand128();
        run(1, a0, a0 ^ p, 1'b0, 1'b0);
        check_run("lat3", p, 81);
    endtask

    task automatic test_stability();
        logic [127:0] a0;
        a0 = rand128();
        run(0, a0, a0 ^ PT, 1'b1, 1'b0);
        check_run("toggle", PT, 161);
    endtask

    task automatic test_start_busy_reset();
        logic [127:0] a0, a1;
        a0 = rand128(); a1 = a0 ^ PT;
        si0 = a0; si1 = a1; r_in = 8'($urandom); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (39) @(posedge clk);
        #1 si0 = ~a0; si1 = ~a1; start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(posedge clk); @(negedge clk); sample(0);
        vectors++;
        if (s_sb0 !== a0[39:32] || s_sb1 !== a1[39:32]) begin
            miscompares++; $display("FAIL busy_start_sbox: got %h/%h required %h/%h", s_sb0, s_sb1, a0[39:32], a1[39:32]);
        end
        vectors++;
        if (s_so0[127:40] !== a0[127:40] || s_busy !== 1'b1) begin
            miscompares++; $display("FAIL busy_start_state: so0 hi %h busy %b required %h 1", s_so0[127:40], s_busy, a0[127:40]);
        end
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1 sample(0);
        vectors++;
        if (s_so0 !== '0 || s_so1 !== '0 || s_busy !== 1'b0 || {s_sb0, s_sb1, s_sbr} !== '0) begin
            miscompares++; $display("FAIL busy_reset: so0=%h busy=%b sb=%h required 0", s_so0, s_busy, {s_sb0, s_sb1, s_sbr});
        end
        @(negedge clk); rst = 1'b0;
        run(0, a0, a1, 1'b0, 1'b0);
        check_run("after_reset", PT, 161);
    endtask

    task automatic test_back_to_back();
        logic [127:0] a0;
        a0 = rand128();
        run(0, a0, a0 ^ PT, 1'b0, 1'b1);
        check_run("b2b", PT, 161);
        @(negedge clk); sample(0);
        vectors++;
        if (s_busy !== 1'b0) begin
            miscompares++; $display("FAIL b2b_idle_cycle: busy=%b required 0", s_busy);
        end
        @(negedge clk); sample(0);
        vectors++;
        if (s_req !== 1'b1 || s_busy !== 1'b1) begin
            miscompares++; $display("FAIL b2b_restart: req=%b busy=%b required 1 1", s_req, s_busy);
        end
        start0 = 1'b0;
        pulse_reset();
    endtask

    initial begin
        test_reset();
        test_zero_state();
        test_random_shares();
        test_lat3();
        test_stability();
        test_start_busy_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
